gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Parametrised successor to the fixed 4-bit binary-to-Gray converter.
- Registered WIDTH-bit up/down counter that presents its count in both binary and Gray code, both glitch-free. Supports load, wrap or saturate at the boundaries, and a terminal-count flag.
- Also contains an independent Gray-to-binary decode channel with a single-step checker, used for incoming Gray pointers (e.g. FIFO pointers after synchronisers).

Parameters:
- WIDTH, 4, bit width of counter, Gray output and decode channel (≥2).
- WRAP, 1, 1 = wrap at max/zero; 0 = saturate (hold) at max/zero.
- RST_VAL, 0, binary reset value of the counter (< 2^WIDTH).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous load of load_bin.
- load_bin  input  WIDTH  binary load value.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray count, equal to bin_out ^ (bin_out >> 1).
- tc  output  1  terminal count: up_dn ? (bin_out == all-ones) : (bin_out == 0).
- wrap_pulse  output  1  one-cycle pulse after a wrap event.
- gray_in  input  WIDTH  Gray value to decode.
- gray_in_vld  input  1  gray_in is valid this cycle.
- bin_chk  output  WIDTH  registered binary decode of last valid gray_in.
- chk_vld  output  1  one-cycle strobe, bin_chk updated.
- step_err  output  1  one-cycle strobe, illegal Gray step detected.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; asserting it at any time, including mid-count, immediately forces every register to its reset value.
- Reset values:
  - bin_out = RST_VAL.
  - gray_out = RST_VAL ^ (RST_VAL >> 1).
  - wrap_pulse = 0, bin_chk = 0, chk_vld = 0, step_err = 0.
  - Internal last_gray = 0; internal seen flag = 0.
- Counter next value (priority order):
  - load: next = load_bin. No wrap_pulse, regardless of en and up_dn.
  - en & up_dn & bin_out ≠ max: next = bin_out + 1.
  - en & up_dn & bin_out = max: WRAP=1 gives next = 0 and wrap_pulse = 1 next cycle; WRAP=0 holds and wrap_pulse stays 0.
  - en & !up_dn & bin_out ≠ 0: next = bin_out - 1.
  - en & !up_dn & bin_out = 0: WRAP=1 gives next = max and wrap_pulse = 1; WRAP=0 holds.
  - !en & !load: hold.
- Gray register: gray_out is registered from gray(next) on the same edge as bin_out. There is no combinational path from the count to gray_out, and gray_out changes by exactly one bit per count step, except on load.
- tc: combinational decode of bin_out and up_dn. It is only meaningful as a boundary indicator. Asserted continuously while saturated.
- wrap_pulse: registered, high for exactly one cycle per wrap; consecutive wraps produce consecutive pulses.
- Arithmetic: binary is modulo 2^WIDTH; no sign.
- Decode channel (independent of the counter):
  - On gray_in_vld, the next edge sets bin_chk = gray2bin(gray_in), where b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i].
  - chk_vld = 1 for one cycle; last_gray = gray_in; seen = 1.
  - step_err = 1 for one cycle iff seen was already 1 and popcount(gray_in ^ last_gray) > 1.
  - Zero-bit difference (repeat value) is legal.
  - The first valid sample after reset never flags.
  - Without gray_in_vld, chk_vld = 0, step_err = 0, and bin_chk and last_gray hold.
- Latency: counter 1 cycle from en/load to outputs; decode 1 cycle from gray_in_vld to bin_chk/chk_vld/step_err.

Test Plan:
- Wrap up: WIDTH=4, WRAP=1, reset, en=1, up_dn=1 for 17 cycles.
  - gray_out sequence: 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - wrap_pulse high only in the cycle gray_out returns to 0000.
  - tc high while bin_out=1111.
- Wrap down: from reset, en=1, up_dn=0 for one cycle -> bin_out=1111, gray_out=1000, wrap_pulse=1 for one cycle.
- Saturate: WRAP=0, load 1110, then count up 3 cycles -> bin_out 1111 held, gray_out 1000, tc=1, wrap_pulse never asserted.
- Load priority: load=1, load_bin=1010 with en=1, up_dn=1 -> next cycle bin_out=1010, gray_out=1111, wrap_pulse=0.
- Decode and checker: valid gray_in 0110, 0111, 0111, 0001 on consecutive cycles.
  - bin_chk: 0100, 0101, 0101, 0001; chk_vld high each cycle.
  - step_err only for 0001 (two bits differ from 0111).
- Async reset mid-count: RST_VAL=5, count to 9, pulse rst between clock edges.
  - bin_out=0101 and gray_out=0111 immediately, without waiting for a clock edge.
  - Next valid gray_in after reset does not raise step_err.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down counter with registered binary and Gray outputs, plus an independent
// Gray-to-binary decode channel that flags multi-bit steps between samples.
module gray_counter #(
  parameter int WIDTH   = 4,
  parameter bit WRAP    = 1'b1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             wrap_pulse,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_in_vld,
  output logic [WIDTH-1:0] bin_chk,
  output logic             chk_vld,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---------------------------------------------------------------- counter
  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    bin_next  = bin_out;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up_dn) begin
        if (bin_out != MAX_VAL) begin
          bin_next = bin_out + ONE;
        end else if (WRAP) begin
          bin_next  = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (bin_out != '0) begin
          bin_next = bin_out - ONE;
        end else if (WRAP) begin
          bin_next  = MAX_VAL;
          wrap_next = 1'b1;
        end
      end
    end
  end

  // Gray is registered from the next binary value so gray_out never sees
  // decode glitches from the count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out    <= RST_BIN;
      gray_out   <= RST_GRAY;
      wrap_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      bin_out    <= bin_next;
      gray_out   <= bin2gray(bin_next);
      wrap_pulse <= wrap_next;
    end
  end

  assign tc = up_dn ? (bin_out == MAX_VAL) : (bin_out == '0);

  // --------------------------------------------------------- decode channel
  logic [WIDTH-1:0] last_gray;
  logic             seen;
  logic [WIDTH-1:0] gray_diff;
  logic             multi_bit;

  // x & (x-1) clears the lowest set bit; anything left means two or more bits.
  assign gray_diff = gray_in ^ last_gray;
  assign multi_bit = |(gray_diff & (gray_diff - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_chk   <= '0;
      chk_vld   <= 1'b0;
      step_err  <= 1'b0;
      last_gray <= '0;
      seen      <= 1'b0;
    end else if (gray_in_vld) begin
      bin_chk   <= gray2bin(gray_in);
      chk_vld   <= 1'b1;
      step_err  <= seen & multi_bit;
      last_gray <= gray_in;
      seen      <= 1'b1;
    end else begin
      chk_vld   <= 1'b0;
      step_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: three parameter variants share stimulus
// and are compared against a behavioural model and the directed expectations.
module tb_gray_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_bin;
  logic [3:0] gray_in;
  logic       gray_in_vld;

  logic [3:0] bin_out    [3];
  logic [3:0] gray_out   [3];
  logic       tc         [3];
  logic       wrap_pulse [3];
  logic [3:0] bin_chk    [3];
  logic       chk_vld    [3];
  logic       step_err   [3];

  // Instance 0: wrap, reset 0. Instance 1: saturate, reset 0. Instance 2: wrap, reset 5.
  int rst_p  [3] = '{0, 0, 5};
  bit wrap_p [3] = '{1'b1, 1'b0, 1'b1};

  int n_cmp = 0;
  int n_err = 0;

  gray_counter #(.WIDTH(4), .WRAP(1'b1), .RST_VAL(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
    .bin_out(bin_out[0]), .gray_out(gray_out[0]), .tc(tc[0]), .wrap_pulse(wrap_pulse[0]),
    .gray_in(gray_in), .gray_in_vld(gray_in_vld),
    .bin_chk(bin_chk[0]), .chk_vld(chk_vld[0]), .step_err(step_err[0]));

  gray_counter #(.WIDTH(4), .WRAP(1'b0), .RST_VAL(0)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
    .bin_out(bin_out[1]), .gray_out(gray_out[1]), .tc(tc[1]), .wrap_pulse(wrap_pulse[1]),
    .gray_in(gray_in), .gray_in_vld(gray_in_vld),
    .bin_chk(bin_chk[1]), .chk_vld(chk_vld[1]), .step_err(step_err[1]));

  gray_counter #(.WIDTH(4), .WRAP(1'b1), .RST_VAL(5)) dut_rst5 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
    .bin_out(bin_out[2]), .gray_out(gray_out[2]), .tc(tc[2]), .wrap_pulse(wrap_pulse[2]),
    .gray_in(gray_in), .gray_in_vld(gray_in_vld),
    .bin_chk(bin_chk[2]), .chk_vld(chk_vld[2]), .step_err(step_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ reference model
  int         m_bin [3];
  logic       m_wp  [3];
  logic [3:0] m_chk;
  logic       m_cv;
  logic       m_se;
  logic [3:0] m_last;
  logic       m_seen;

  // Decode by search: the binary value whose Gray image equals g.
  function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
    logic [3:0] v;
    for (int n = 0; n < 16; n++) begin
      v = 4'(n);
      if ((v ^ (v >> 1)) == g) return v;
    end
    return 4'hx;
  endfunction

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] v;
    v = 4'(n);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_bin[k] = rst_p[k];
      m_wp[k]  = 1'b0;
    end
    m_chk  = '0;
    m_cv   = 1'b0;
    m_se   = 1'b0;
    m_last = '0;
    m_seen = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      m_wp[k] = 1'b0;
      if (load) begin
        m_bin[k] = int'(load_bin);
      end else if (en && up_dn) begin
        if (m_bin[k] < 15)  m_bin[k] = m_bin[k] + 1;
        else if (wrap_p[k]) begin m_bin[k] = 0; m_wp[k] = 1'b1; end
      end else if (en) begin
        if (m_bin[k] > 0)   m_bin[k] = m_bin[k] - 1;
        else if (wrap_p[k]) begin m_bin[k] = 15; m_wp[k] = 1'b1; end
      end
    end
    if (gray_in_vld) begin
      m_cv   = 1'b1;
      m_se   = m_seen && ($countones(gray_in ^ m_last) > 1);
      m_chk  = gray_to_bin(gray_in);
      m_last = gray_in;
      m_seen = 1'b1;
    end else begin
      m_cv = 1'b0;
      m_se = 1'b0;
    end
  endtask

  // Advance one clock; the model follows the edge, outputs are read at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; up_dn = 1'b1; gray_in_vld = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = '0;
    gray_in = '0; gray_in_vld = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bin_out[k] !== 4'(rst_p[k])) begin n_err++;
        $display("FAIL reset_bin[%0d]: got %b want %b", k, bin_out[k], 4'(rst_p[k])); end
      n_cmp++; if (gray_out[k] !== to_gray(rst_p[k])) begin n_err++;
        $display("FAIL reset_gray[%0d]: got %b want %b", k, gray_out[k], to_gray(rst_p[k])); end
      n_cmp++; if ({wrap_pulse[k], chk_vld[k], step_err[k], bin_chk[k]} !== 7'b0) begin n_err++;
        $display("FAIL reset_flags[%0d]: got wp=%b cv=%b se=%b chk=%b want all zero",
                 k, wrap_pulse[k], chk_vld[k], step_err[k], bin_chk[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_seq [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                 4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    apply_reset();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) tick();
      n_cmp++; if (gray_out[0] !== ((i < 17) ? exp_seq[i] : 4'b0001)) begin n_err++;
        $display("FAIL wrap_up_gray step %0d: got %b want %b", i, gray_out[0],
                 (i < 17) ? exp_seq[i] : 4'b0001); end
      n_cmp++; if (wrap_pulse[0] !== 1'(i == 16)) begin n_err++;
        $display("FAIL wrap_up_pulse step %0d: got %b want %b", i, wrap_pulse[0], 1'(i == 16)); end
      n_cmp++; if (tc[0] !== 1'(i == 15)) begin n_err++;
        $display("FAIL wrap_up_tc step %0d: got %b want %b", i, tc[0], 1'(i == 15)); end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap_down();
    apply_reset();
    en = 1'b1; up_dn = 1'b0;
    tick();
    n_cmp++; if ({bin_out[0], gray_out[0], wrap_pulse[0]} !== {4'b1111, 4'b1000, 1'b1}) begin n_err++;
      $display("FAIL wrap_down: got bin=%b gray=%b wp=%b want 1111 1000 1", bin_out[0], gray_out[0], wrap_pulse[0]); end
    n_cmp++; if ({bin_out[1], wrap_pulse[1], tc[1]} !== {4'b0000, 1'b0, 1'b1}) begin n_err++;
      $display("FAIL sat_floor: got bin=%b wp=%b tc=%b want 0000 0 1", bin_out[1], wrap_pulse[1], tc[1]); end
    en = 1'b0;
    tick();
    n_cmp++; if ({bin_out[0], wrap_pulse[0]} !== {4'b1111, 1'b0}) begin n_err++;
      $display("FAIL wrap_down_after: got bin=%b wp=%b want 1111 0", bin_out[0], wrap_pulse[0]); end
  endtask

  task automatic test_saturate();
    apply_reset();
    load = 1'b1; load_bin = 4'b1110;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({bin_out[1], gray_out[1], tc[1], wrap_pulse[1]} !== {4'b1111, 4'b1000, 1'b1, 1'b0}) begin n_err++;
        $display("FAIL saturate cyc %0d: got bin=%b gray=%b tc=%b wp=%b want 1111 1000 1 0",
                 i, bin_out[1], gray_out[1], tc[1], wrap_pulse[1]); end
      n_cmp++; if (bin_out[0] !== 4'(m_bin[0])) begin n_err++;
        $display("FAIL saturate_wrapinst cyc %0d: got %b want %b", i, bin_out[0], 4'(m_bin[0])); end
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_bin = 4'b1111; en = 1'b0;
    tick();
    load_bin = 4'b1010; en = 1'b1; up_dn = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if ({bin_out[k], gray_out[k], wrap_pulse[k]} !== {4'b1010, 4'b1111, 1'b0}) begin n_err++;
        $display("FAIL load_priority[%0d]: got bin=%b gray=%b wp=%b want 1010 1111 0",
                 k, bin_out[k], gray_out[k], wrap_pulse[k]); end
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_decode();
    logic [3:0] gin   [4] = '{4'b0110, 4'b0111, 4'b0111, 4'b0001};
    logic [3:0] exp_b [4] = '{4'b0100, 4'b0101, 4'b0101, 4'b0001};
    logic       exp_e [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      gray_in_vld = 1'b1; gray_in = gin[i];
      tick();
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if ({bin_chk[k], chk_vld[k], step_err[k]} !== {exp_b[i], 1'b1, exp_e[i]}) begin n_err++;
          $display("FAIL decode[%0d] sample %0d: got chk=%b cv=%b se=%b want %b 1 %b",
                   k, i, bin_chk[k], chk_vld[k], step_err[k], exp_b[i], exp_e[i]); end
      end
    end
    gray_in_vld = 1'b0; gray_in = 4'b1111;
    tick();
    n_cmp++; if ({bin_chk[0], chk_vld[0], step_err[0]} !== {4'b0001, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL decode_idle: got chk=%b cv=%b se=%b want 0001 0 0", bin_chk[0], chk_vld[0], step_err[0]); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    gray_in_vld = 1'b1; gray_in = 4'b0000;
    tick();
    gray_in_vld = 1'b0; en = 1'b1; up_dn = 1'b1;
    repeat (4) tick();
    n_cmp++; if (bin_out[2] !== 4'b1001) begin n_err++;
      $display("FAIL async_precount: got %b want 1001", bin_out[2]); end
    en = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if ({bin_out[2], gray_out[2]} !== {4'b0101, 4'b0111}) begin n_err++;
      $display("FAIL async_reset: got bin=%b gray=%b want 0101 0111", bin_out[2], gray_out[2]); end
    #1 rst = 1'b0;
    tick();
    gray_in_vld = 1'b1; gray_in = 4'b0011;
    tick();
    n_cmp++; if ({bin_chk[2], chk_vld[2], step_err[2]} !== {4'b0010, 1'b1, 1'b0}) begin n_err++;
      $display("FAIL async_first_sample: got chk=%b cv=%b se=%b want 0010 1 0", bin_chk[2], chk_vld[2], step_err[2]); end
    gray_in_vld = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] exp_g;
    logic       exp_tc;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      load_bin = 4'($urandom);
      gray_in_vld = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       gray_in = 4'($urandom);
        1:       gray_in = gray_in;
        default: gray_in = gray_in ^ (4'b0001 << $urandom_range(0, 3));
      endcase
      tick();
      for (int k = 0; k < 3; k++) begin
        exp_g  = to_gray(m_bin[k]);
        exp_tc = up_dn ? (m_bin[k] == 15) : (m_bin[k] == 0);
        n_cmp++; if (bin_out[k] !== 4'(m_bin[k])) begin n_err++;
          $display("FAIL rand_bin[%0d] cyc %0d: got %b want %b", k, c, bin_out[k], 4'(m_bin[k])); end
        n_cmp++; if (gray_out[k] !== exp_g) begin n_err++;
          $display("FAIL rand_gray[%0d] cyc %0d: got %b want %b", k, c, gray_out[k], exp_g); end
        n_cmp++; if (tc[k] !== exp_tc) begin n_err++;
          $display("FAIL rand_tc[%0d] cyc %0d: got %b want %b", k, c, tc[k], exp_tc); end
        n_cmp++; if (wrap_pulse[k] !== m_wp[k]) begin n_err++;
          $display("FAIL rand_wp[%0d] cyc %0d: got %b want %b", k, c, wrap_pulse[k], m_wp[k]); end
        n_cmp++; if ({bin_chk[k], chk_vld[k], step_err[k]} !== {m_chk, m_cv, m_se}) begin n_err++;
          $display("FAIL rand_decode[%0d] cyc %0d: got chk=%b cv=%b se=%b want %b %b %b",
                   k, c, bin_chk[k], chk_vld[k], step_err[k], m_chk, m_cv, m_se); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_priority();
    test_decode();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
